// File: rtl/lcd_pkg.sv
// Shared definitions for the HD44780 character LCD read and write paths.
package lcd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_EN_HI,
        ST_HOLD,
        ST_RECOVER,
        ST_DONE
    } lcd_state_e;

    localparam logic LCD_RS_CMD  = 1'b0;
    localparam logic LCD_RS_DATA = 1'b1;
    localparam int   BF_BIT      = 7;

    // Default bus timing in 50 MHz clock cycles.
    localparam int DEF_T_SETUP    = 2;
    localparam int DEF_T_EN_HI    = 25;
    localparam int DEF_T_HOLD     = 1;
    localparam int DEF_T_RECOVER  = 25;
    localparam int DEF_POLL_LIMIT = 50000;

    function automatic int cntWidth(input int maxValue);
        return (maxValue > 1) ? $clog2(maxValue) : 1;
    endfunction

    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/lcd_timer.sv
// Loadable down-counter with a zero flag; paces every LCD bus phase.
module lcd_timer
#(
    parameter int WIDTH = 5
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] value_i,
    output logic             zero_o
);

    logic [WIDTH-1:0] count_q;

    // Saturates at zero so a state that lingers never wraps around.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= value_i;
        end else if (count_q != '0) begin
            count_q <= count_q - WIDTH'(1);
        end
    end

    assign zero_o = (count_q == '0);

endmodule

// File: rtl/lcd_reader.sv
// HD44780 read-cycle engine: busy-flag/address or data reads, with optional
// busy-flag polling that gives up after POLL_LIMIT reads.
module lcd_reader
    import lcd_pkg::*;
#(
    parameter int T_SETUP    = DEF_T_SETUP,
    parameter int T_EN_HI    = DEF_T_EN_HI,
    parameter int T_HOLD     = DEF_T_HOLD,
    parameter int T_RECOVER  = DEF_T_RECOVER,
    parameter int POLL_LIMIT = DEF_POLL_LIMIT
) (
    input  logic       CLOCK_50,
    input  logic       RESET,
    input  logic       rd_req,
    input  logic       rd_rs,
    input  logic       rd_poll,
    output logic       rd_ready,
    output logic       rd_valid,
    output logic [7:0] rd_data,
    output logic       rd_busy,
    output logic [6:0] rd_addr,
    output logic       rd_timeout,
    input  logic [7:0] LCD_DATA_IN,
    output logic       LCD_RW,
    output logic       LCD_RS,
    output logic       LCD_EN
);

    localparam int CW = cntWidth(max4(T_SETUP, T_EN_HI, T_HOLD, T_RECOVER));
    localparam int PW = cntWidth(POLL_LIMIT);

    if (T_SETUP < 1 || T_EN_HI < 1 || T_HOLD < 1 || T_RECOVER < 1 || POLL_LIMIT < 1) begin : gBadParam
        $error("lcd_reader: timing parameters and POLL_LIMIT must be at least 1");
    end

    lcd_state_e      state_q;
    logic            lcdEn_q, lcdRw_q, lcdRs_q, pollMode_q;
    logic [PW-1:0]   pollCnt_q;
    logic [7:0]      sample_q, rdData_q;
    logic [6:0]      rdAddr_q;
    logic            rdBusy_q, rdValid_q, rdTimeout_q, rdReady_q;

    logic            accept, stillBusy, pollAgain;
    logic            timerLoad, timerZero;
    logic [CW-1:0]   timerValue;

    assign accept    = rd_req & rdReady_q;
    assign stillBusy = pollMode_q & sample_q[BF_BIT];
    assign pollAgain = stillBusy & (pollCnt_q != '0);

    // Reload the timer with the length of whichever state is entered next.
    always_comb begin
        timerLoad  = (state_q == ST_IDLE) ? accept : timerZero;
        timerValue = '0;
        case (state_q)
            ST_IDLE:    timerValue = CW'(T_SETUP - 1);
            ST_SETUP:   timerValue = CW'(T_EN_HI - 1);
            ST_EN_HI:   timerValue = CW'(T_HOLD - 1);
            ST_HOLD:    timerValue = CW'(T_RECOVER - 1);
            ST_RECOVER: if (pollAgain) timerValue = CW'(T_SETUP - 1);
            default:    ;
        endcase
    end

    lcd_timer #(.WIDTH(CW)) uTimer (
        .clk_i   (CLOCK_50),
        .reset_i (RESET),
        .load_i  (timerLoad),
        .value_i (timerValue),
        .zero_o  (timerZero)
    );

    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            state_q     <= ST_IDLE;
            lcdEn_q     <= 1'b0;
            lcdRw_q     <= 1'b0;
            lcdRs_q     <= 1'b0;
            pollMode_q  <= 1'b0;
            pollCnt_q   <= '0;
            sample_q    <= '0;
            rdData_q    <= '0;
            rdAddr_q    <= '0;
            rdBusy_q    <= 1'b0;
            rdValid_q   <= 1'b0;
            rdTimeout_q <= 1'b0;
            rdReady_q   <= 1'b1;
        end else begin
            rdValid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        lcdRs_q     <= rd_rs;
                        pollMode_q  <= rd_poll & (rd_rs == LCD_RS_CMD);
                        pollCnt_q   <= PW'(POLL_LIMIT - 1);
                        rdTimeout_q <= 1'b0;
                        rdReady_q   <= 1'b0;
                        lcdRw_q     <= 1'b1;
                        state_q     <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (timerZero) begin
                        lcdEn_q <= 1'b1;
                        state_q <= ST_EN_HI;
                    end
                end
                ST_EN_HI: begin
                    if (timerZero) begin
                        lcdEn_q  <= 1'b0;
                        sample_q <= LCD_DATA_IN;
                        state_q  <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (timerZero) begin
                        lcdRw_q <= 1'b0;
                        state_q <= ST_RECOVER;
                    end
                end
                ST_RECOVER: begin
                    if (timerZero) begin
                        if (pollAgain) begin
                            pollCnt_q <= pollCnt_q - PW'(1);
                            lcdRw_q   <= 1'b1;
                            state_q   <= ST_SETUP;
                        end else begin
                            rdTimeout_q <= stillBusy;
                            rdData_q    <= sample_q;
                            rdBusy_q    <= (lcdRs_q == LCD_RS_DATA) ? 1'b0 : sample_q[BF_BIT];
                            rdAddr_q    <= (lcdRs_q == LCD_RS_DATA) ? 7'd0 : sample_q[6:0];
                            rdValid_q   <= 1'b1;
                            state_q     <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    rdReady_q <= 1'b1;
                    state_q   <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign rd_ready   = rdReady_q;
    assign rd_valid   = rdValid_q;
    assign rd_data    = rdData_q;
    assign rd_busy    = rdBusy_q;
    assign rd_addr    = rdAddr_q;
    assign rd_timeout = rdTimeout_q;
    assign LCD_RW     = lcdRw_q;
    assign LCD_RS     = lcdRs_q;
    assign LCD_EN     = lcdEn_q;

endmodule
